span_setup: RTL and testbench
=============================

Name: span_setup

Overview:
- Per-span setup stage directly upstream of the horizontal-line z-buffer engine (hline_zbuff FSM).
- Accepts one raw span (two endpoints, scanline y, colour) from the triangle rasterizer over a valid/ready handshake.
- Orders the endpoints and computes pixel count, integer z slope, remainder, initial error, and the frame-buffer and z-buffer start addresses; a serial divider produces the slope.
- Drives the engine's start/done handshake and holds all span parameters stable until the engine reports completion.

Parameters:
- PITCH_SHIFT, 11, log2 of the scanline pitch in bytes (2048 B = 512 px × 4 B).
- DIV_W, 32, dividend width and divider iteration count.

Ports:
- clk  in  1  clock
- nreset  in  1  synchronous active-low reset
- span_valid  in  1  upstream span available
- span_ready  out  1  block can accept a span
- x1, x2  in  16 each  endpoint x, unsigned, either order
- y  in  16  scanline
- z1, z2  in  32 each  endpoint depths, unsigned, < 2^31
- rgbx_in  in  32  span colour
- fb_base, zb_base  in  32 each  buffer base byte addresses, sampled on accept
- fb_addr, zbuff_addr  out  32 each  span start byte addresses
- dx  out  32  pixel count
- slope  out  32  signed integer z step per pixel
- rem  out  32  |dz| mod dx
- err  out  32  initial error term
- z1_out  out  32  z at left endpoint
- rgbx  out  32  registered colour
- hl_start  out  1  one-cycle start pulse to the engine
- hl_done  in  1  engine done (level; stays high until the next start)
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE. Reset in any state aborts the span; no hl_start is issued afterwards.
- Accept: span_ready = (state == IDLE). A span is accepted when span_valid & span_ready; all inputs are captured that cycle (cycle T).
- SETUP (T+1):
  - If x1 > x2, swap the x and z endpoints; xl/zl are the left endpoint.
  - dx = xr − xl + 1, range 1..65536, zero-extended to 32 bits.
  - dz = zr − zl as a 32-bit two's-complement value; store |dz| and its sign.
  - fb_addr = fb_base + (y << PITCH_SHIFT) + (xl << 2); zbuff_addr uses zb_base with the same offset; 32-bit wrap.
  - z1_out = zl; rgbx = captured colour.
- DIV (T+2..T+1+DIV_W): restoring divide of |dz| by dx, one quotient bit per cycle, MSB first. dx ≥ 1, so there is no divide-by-zero path.
- FIX (T+2+DIV_W):
  - slope = sign ? −q : q (truncation toward zero).
  - rem = |dz| − q·dx, taken from the divider remainder register.
  - err = 0.
- START (T+3+DIV_W, T+35 by default): hl_start = 1 for exactly one cycle.
- WAIT_BUSY: wait for hl_done == 0. The engine's done may still be high from the previous span, so it must be seen low first.
- WAIT_DONE: wait for hl_done == 1, then go to IDLE; span_ready rises the next cycle.
- All parameter outputs are registered and stay constant from FIX until the next accept.
- hl_done during IDLE, SETUP, DIV or FIX is ignored.

Optional Feature:
- Macro: SPAN_ROUND_ERR_EN.
- Defined: err = dx >> 1 in FIX, so the engine's carry steps round to nearest instead of truncating. Example: dx = 10 gives err = 5.
- Undefined: err = 0.
- No other output or timing changes in either case.

Test Plan:
- Basic span: x1=10, x2=13, z1=100, z2=110, y=2, fb_base=0x10000000, zb_base=0x20000000.
  - Outputs: dx=4, slope=2, rem=2, err=0, z1_out=100.
  - Addresses: fb_addr=0x10001028, zbuff_addr=0x20001028.
  - hl_start is high in exactly cycle T+35.
- Swapped endpoints: x1=20, x2=11, z1=50, z2=5 → z1_out=5, dx=10, slope=4, rem=5; fb_addr offset = 44 + (y << 11).
- Negative slope: x1=0, x2=2, z1=10, z2=0 → dx=3, slope=0xFFFFFFFD (−3), rem=1, z1_out=0.
- Single pixel and max span:
  - x1=x2=7, z1=z2=3 → dx=1, slope=0, rem=0.
  - x1=0, x2=0xFFFF, z1=0, z2=0x10000 → dx=65536, slope=1, rem=0.
- Done handshake: hl_done held high from the previous span, then low 2 cycles after hl_start, then high 300 cycles later.
  - Exactly one hl_start pulse.
  - span_ready stays 0 until the cycle after hl_done rises.
  - A second queued span is accepted that cycle.
- Reset mid-DIV: nreset=0 for 1 cycle at T+10.
  - All outputs read 0 and state is IDLE.
  - span_ready=1 the cycle after reset deasserts.
  - No hl_start occurs.
  - With SPAN_ROUND_ERR_EN defined, the basic span gives err=2.

Source files
------------

// File: rtl/span_setup.sv
// Span setup ahead of the hline_zbuff engine: endpoint ordering, addresses and a serial z-slope divide.
// Optional build macro SPAN_ROUND_ERR_EN seeds the error term with dx/2 for round-to-nearest stepping.
module span_setup #(
  parameter int PITCH_SHIFT = 11,
  parameter int DIV_W       = 32
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        span_valid,
  output logic        span_ready,
  input  logic [15:0] x1,
  input  logic [15:0] x2,
  input  logic [15:0] y,
  input  logic [31:0] z1,
  input  logic [31:0] z2,
  input  logic [31:0] rgbx_in,
  input  logic [31:0] fb_base,
  input  logic [31:0] zb_base,
  output logic [31:0] fb_addr,
  output logic [31:0] zbuff_addr,
  output logic [31:0] dx,
  output logic [31:0] slope,
  output logic [31:0] rem,
  output logic [31:0] err,
  output logic [31:0] z1_out,
  output logic [31:0] rgbx,
  output logic        hl_start,
  input  logic        hl_done,
  output logic        busy
);

  localparam int CNT_W = $clog2(DIV_W) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, DIV, FIX, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t state, state_next;

  logic [15:0] x1_p0, x2_p0, y_p0;
  logic [31:0] z1_p0, z2_p0, rgbx_p0, fb_base_p0, zb_base_p0;

  logic              swap;
  logic [15:0]       xl, xr;
  logic [31:0]       zl, zr;
  logic signed [31:0] dz;
  logic [31:0]       dz_abs, dx_calc, offset;

  logic [DIV_W-1:0] div_q;
  logic [DIV_W:0]   div_r, div_d, r_shift, r_sub;
  logic             div_sign, take;
  logic [CNT_W-1:0] cnt;
  logic signed [31:0] quo_s;

  function automatic logic [31:0] init_err(input logic [31:0] count);
`ifdef SPAN_ROUND_ERR_EN
    return count >> 1;
`else
    return 32'(count & 32'd0);
`endif
  endfunction

  assign span_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!nreset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (span_valid) state_next = SETUP;
      SETUP:     state_next = DIV;
      DIV:       if (cnt == CNT_W'(DIV_W - 1)) state_next = FIX;
      FIX:       state_next = START;
      START:     state_next = WAIT_BUSY;
      // done may still be high from the previous span, so see it drop first
      WAIT_BUSY: if (!hl_done) state_next = WAIT_DONE;
      WAIT_DONE: if (hl_done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    swap    = (x1_p0 > x2_p0);
    xl      = swap ? x2_p0 : x1_p0;
    xr      = swap ? x1_p0 : x2_p0;
    zl      = swap ? z2_p0 : z1_p0;
    zr      = swap ? z1_p0 : z2_p0;
    dx_calc = {16'd0, xr} - {16'd0, xl} + 32'd1;
    dz      = $signed(zr - zl);
    dz_abs  = dz[31] ? $unsigned(-dz) : $unsigned(dz);
    offset  = ({16'd0, y_p0} << PITCH_SHIFT) + ({16'd0, xl} << 2);
    r_shift = {div_r[DIV_W-1:0], div_q[DIV_W-1]};
    r_sub   = r_shift - div_d;
    take    = (r_shift >= div_d);
    quo_s   = $signed(32'(div_q));
  end

  // Stage p0: capture on accept; then serial restoring divide, one quotient bit per cycle
  always_ff @(posedge clk) begin
    if (state == IDLE && span_valid) begin
      x1_p0      <= x1;
      x2_p0      <= x2;
      y_p0       <= y;
      z1_p0      <= z1;
      z2_p0      <= z2;
      rgbx_p0    <= rgbx_in;
      fb_base_p0 <= fb_base;
      zb_base_p0 <= zb_base;
    end
    if (state == SETUP) begin
      div_q    <= DIV_W'(dz_abs);
      div_r    <= '0;
      div_d    <= (DIV_W + 1)'(dx_calc);
      div_sign <= dz[31];
      cnt      <= '0;
    end else if (state == DIV) begin
      div_q <= {div_q[DIV_W-2:0], take};
      div_r <= take ? r_sub : r_shift;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // Stage p1: registered span parameters for the engine
  always_ff @(posedge clk) begin
    if (!nreset) begin
      fb_addr    <= '0;
      zbuff_addr <= '0;
      dx         <= '0;
      slope      <= '0;
      rem        <= '0;
      err        <= '0;
      z1_out     <= '0;
      rgbx       <= '0;
      hl_start   <= 1'b0;
    end else begin
      hl_start <= (state == FIX);
      if (state == SETUP) begin
        dx         <= dx_calc;
        fb_addr    <= fb_base_p0 + offset;
        zbuff_addr <= zb_base_p0 + offset;
        z1_out     <= zl;
        rgbx       <= rgbx_p0;
      end
      if (state == FIX) begin
        slope <= div_sign ? -quo_s : quo_s;
        rem   <= 32'(div_r);
        err   <= init_err(dx);
      end
    end
  end

endmodule

// File: tb/tb_span_setup.sv
// Self-checking bench for span_setup: directed test-plan spans, random spans, done handshake and abort.
module tb_span_setup;

  logic        clk = 1'b0;
  logic        nreset, span_valid, span_ready, hl_start, hl_done, busy;
  logic [15:0] x1, x2, y;
  logic [31:0] z1, z2, rgbx_in, fb_base, zb_base;
  logic [31:0] fb_addr, zbuff_addr, dx, slope, rem, err, z1_out, rgbx;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] fb, zb, dx, slope, rem, err, z1o, rgbx;
  } res_t;

  span_setup dut (
    .clk(clk), .nreset(nreset), .span_valid(span_valid), .span_ready(span_ready),
    .x1(x1), .x2(x2), .y(y), .z1(z1), .z2(z2), .rgbx_in(rgbx_in),
    .fb_base(fb_base), .zb_base(zb_base), .fb_addr(fb_addr), .zbuff_addr(zbuff_addr),
    .dx(dx), .slope(slope), .rem(rem), .err(err), .z1_out(z1_out), .rgbx(rgbx),
    .hl_start(hl_start), .hl_done(hl_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: pixel count, truncating signed divide and byte addresses from plain integer arithmetic
  function automatic res_t model(input logic [15:0] a1, a2, ay,
                                 input logic [31:0] b1, b2, c, fbb, zbb);
    longint xl, xr, zl, zr, n, dzl, q, r, fa, za;
    res_t e;
    if (a1 > a2) begin xl = a2; xr = a1; zl = b2; zr = b1; end
    else         begin xl = a1; xr = a2; zl = b1; zr = b2; end
    n   = xr - xl + 1;
    dzl = zr - zl;
    q   = dzl / n;
    r   = (dzl < 0 ? -dzl : dzl) % n;
    fa  = longint'(fbb) + longint'(ay) * 2048 + xl * 4;
    za  = longint'(zbb) + longint'(ay) * 2048 + xl * 4;
    e.fb    = fa[31:0];
    e.zb    = za[31:0];
    e.dx    = n[31:0];
    e.slope = q[31:0];
    e.rem   = r[31:0];
`ifdef SPAN_ROUND_ERR_EN
    e.err   = 32'(n / 2);
`else
    e.err   = 32'd0;
`endif
    e.z1o   = zl[31:0];
    e.rgbx  = c;
    return e;
  endfunction

  function automatic res_t obs();
    res_t o;
    o.fb = fb_addr; o.zb = zbuff_addr; o.dx = dx; o.slope = slope;
    o.rem = rem; o.err = err; o.z1o = z1_out; o.rgbx = rgbx;
    return o;
  endfunction

  task automatic set_span(input logic [15:0] a1, a2, ay,
                          input logic [31:0] b1, b2, c, fbb, zbb);
    x1 = a1; x2 = a2; y = ay; z1 = b1; z2 = b2; rgbx_in = c; fb_base = fbb; zb_base = zbb;
  endtask

  task automatic accept(output bit ok);
    int k = 0;
    span_valid = 1'b1;
    while (span_ready !== 1'b1 && k < 500) begin @(posedge clk); #1; k++; end
    ok = (span_ready === 1'b1);
    @(posedge clk); #1;
    span_valid = 1'b0;
  endtask

  // Runs the engine side after accept: n counts cycles from T+1 to the start pulse
  task automatic finish_span(output int n, output res_t o, output logic after, output bit ok);
    int k = 0;
    n = 1;
    while (hl_start !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    o = obs();
    @(posedge clk); #1; after = hl_start;
    @(posedge clk); #1; hl_done = 1'b0;
    repeat (3) @(posedge clk);
    #1; hl_done = 1'b1;
    while (span_ready !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    ok = (span_ready === 1'b1) && (n < 200);
  endtask

  task automatic test_reset();
    res_t zero = '0;
    nreset = 1'b0; span_valid = 1'b0; hl_done = 1'b1;
    set_span(16'd0, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs() !== zero || hl_start !== 1'b0) begin
      bad++; $display("FAIL reset_outputs got=%h start=%b want=0", obs(), hl_start);
    end
    total++;
    if (span_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_state ready=%b busy=%b want ready=1 busy=0", span_ready, busy);
    end
    nreset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit ok, ok2; int n; res_t o, e; logic after;
    set_span(16'd10, 16'd13, 16'd2, 32'd100, 32'd110, 32'hCAFE0001, 32'h10000000, 32'h20000000);
    e = model(16'd10, 16'd13, 16'd2, 32'd100, 32'd110, 32'hCAFE0001, 32'h10000000, 32'h20000000);
    accept(ok);
    finish_span(n, o, after, ok2);
    total++;
    if (!ok || !ok2) begin bad++; $display("FAIL basic_handshake accept=%0d done=%0d want 1 1", ok, ok2); end
    total++;
    if (n !== 35 || after !== 1'b0) begin
      bad++; $display("FAIL basic_start_cycle got=T+%0d next=%b want T+35 next=0", n, after);
    end
    total++;
    if (o !== e) begin bad++; $display("FAIL basic_model got=%h want=%h", o, e); end
    total++;
    if (o.dx !== 32'd4 || o.slope !== 32'd2 || o.rem !== 32'd2 || o.z1o !== 32'd100) begin
      bad++; $display("FAIL basic_values dx=%0d slope=%0d rem=%0d z1=%0d want 4 2 2 100",
                      o.dx, o.slope, o.rem, o.z1o);
    end
    total++;
    if (o.fb !== 32'h10001028 || o.zb !== 32'h20001028) begin
      bad++; $display("FAIL basic_addr fb=%h zb=%h want 10001028 20001028", o.fb, o.zb);
    end
    total++;
`ifdef SPAN_ROUND_ERR_EN
    if (o.err !== 32'd2) begin bad++; $display("FAIL basic_err got=%0d want=2", o.err); end
`else
    if (o.err !== 32'd0) begin bad++; $display("FAIL basic_err got=%0d want=0", o.err); end
`endif
  endtask

  task automatic test_vectors();
    logic [15:0] ta1[4] = '{16'd20, 16'd0, 16'd7, 16'd0};
    logic [15:0] ta2[4] = '{16'd11, 16'd2, 16'd7, 16'hFFFF};
    logic [31:0] tz1[4] = '{32'd50, 32'd10, 32'd3, 32'd0};
    logic [31:0] tz2[4] = '{32'd5, 32'd0, 32'd3, 32'h10000};
    logic [31:0] tsl[4] = '{32'd4, 32'hFFFFFFFD, 32'd0, 32'd1};
    logic [31:0] trm[4] = '{32'd5, 32'd1, 32'd0, 32'd0};
    logic [31:0] tdx[4] = '{32'd10, 32'd3, 32'd1, 32'd65536};
    for (int i = 0; i < 4; i++) begin
      bit ok, ok2; int n; res_t o, e; logic after;
      set_span(ta1[i], ta2[i], 16'd3, tz1[i], tz2[i], 32'h00FF00FF, 32'h00400000, 32'h00800000);
      e = model(ta1[i], ta2[i], 16'd3, tz1[i], tz2[i], 32'h00FF00FF, 32'h00400000, 32'h00800000);
      accept(ok);
      finish_span(n, o, after, ok2);
      total++;
      if (!ok || !ok2 || n !== 35 || o !== e) begin
        bad++; $display("FAIL vector%0d start=T+%0d got=%h want=%h", i, n, o, e);
      end
      total++;
      if (o.slope !== tsl[i] || o.rem !== trm[i] || o.dx !== tdx[i]) begin
        bad++; $display("FAIL vector%0d_values slope=%h rem=%0d dx=%0d want %h %0d %0d",
                        i, o.slope, o.rem, o.dx, tsl[i], trm[i], tdx[i]);
      end
    end
    total++;
    if (fb_addr !== 32'h00400000 + (32'd3 << 11) + 32'd0) begin
      bad++; $display("FAIL max_span_addr got=%h want=%h", fb_addr, 32'h00400000 + (32'd3 << 11));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      bit ok, ok2; int n; res_t o, e; logic after;
      logic [15:0] a1, a2, ay; logic [31:0] b1, b2, c, fbb, zbb;
      a1 = 16'($urandom);
      a2 = ($urandom % 2) ? 16'($urandom) : a1 + 16'($urandom_range(0, 40));
      ay = 16'($urandom);
      b1 = $urandom & 32'h7FFFFFFF;
      b2 = ($urandom % 2) ? ($urandom & 32'h7FFFFFFF) : (b1 ^ 32'($urandom_range(0, 4095)));
      c = $urandom; fbb = $urandom; zbb = $urandom;
      set_span(a1, a2, ay, b1, b2, c, fbb, zbb);
      e = model(a1, a2, ay, b1, b2, c, fbb, zbb);
      accept(ok);
      finish_span(n, o, after, ok2);
      total++;
      if (!ok || !ok2 || n !== 35 || after !== 1'b0 || o !== e) begin
        bad++; $display("FAIL random%0d start=T+%0d got=%h want=%h", i, n, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok, ok2; int n, pulses, early; res_t o, e; logic after;
    logic [15:0] a1, a2; logic [31:0] b1, b2;
    set_span(16'd10, 16'd13, 16'd2, 32'd100, 32'd110, 32'h1, 32'h10000000, 32'h20000000);
    accept(ok);
    pulses = 0; early = 0; n = 1;
    while (hl_start !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (hl_start === 1'b1) pulses++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    hl_done = 1'b0;
    a1 = 16'($urandom); a2 = 16'($urandom);
    b1 = $urandom & 32'h7FFFFFFF; b2 = $urandom & 32'h7FFFFFFF;
    set_span(a1, a2, 16'd77, b1, b2, 32'h5A5A5A5A, 32'h0, 32'h40000000);
    e = model(a1, a2, 16'd77, b1, b2, 32'h5A5A5A5A, 32'h0, 32'h40000000);
    span_valid = 1'b1;
    repeat (300) begin
      @(posedge clk); #1;
      if (hl_start === 1'b1) pulses++;
      if (span_ready !== 1'b0) early++;
    end
    hl_done = 1'b1;
    total++;
    if (pulses != 1 || early != 0 || !ok) begin
      bad++; $display("FAIL b2b_wait pulses=%0d early_ready=%0d want pulses=1 early=0", pulses, early);
    end
    @(posedge clk); #1;
    total++;
    if (span_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_done got=%b want=1", span_ready); end
    @(posedge clk); #1;
    span_valid = 1'b0;
    total++;
    if (span_ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL b2b_second_accept ready=%b busy=%b want 0 1", span_ready, busy);
    end
    finish_span(n, o, after, ok2);
    total++;
    if (!ok2 || n !== 35 || o !== e) begin
      bad++; $display("FAIL b2b_second_span start=T+%0d got=%h want=%h", n, o, e);
    end
  endtask

  task automatic test_reset_mid_div();
    bit ok; int pulses = 0, busy_cnt = 0; res_t zero = '0;
    set_span(16'd100, 16'd40, 16'd9, 32'd5000, 32'd90, 32'h12345678, 32'h11111111, 32'h22222222);
    accept(ok);
    repeat (9) @(posedge clk);
    #1; nreset = 1'b0;
    @(posedge clk); #1; nreset = 1'b1;
    total++;
    if (!ok || obs() !== zero || hl_start !== 1'b0) begin
      bad++; $display("FAIL abort_outputs got=%h want=0", obs());
    end
    total++;
    if (span_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_state ready=%b busy=%b want 1 0", span_ready, busy);
    end
    repeat (60) begin
      @(posedge clk); #1;
      if (hl_start === 1'b1) pulses++;
      if (busy !== 1'b0) busy_cnt++;
    end
    total++;
    if (pulses != 0 || busy_cnt != 0) begin
      bad++; $display("FAIL abort_no_start pulses=%0d busy_cycles=%0d want 0 0", pulses, busy_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_random();
    test_back_to_back();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
